// File: rtl/conv_host_mem_pkg.sv
// Shared constants, state encoding and error-bit positions for the CONV host memory block.
package conv_pkg;
  localparam int IMG_W    = 64;
  localparam int IMG_AW   = $clog2(IMG_W);
  localparam int ADDR_W   = 2 * IMG_AW;
  localparam int DATA_W   = 20;
  localparam int L0_DEPTH = 4096;
  localparam int L1_DEPTH = 1024;
  localparam int L1_AW    = $clog2(L1_DEPTH);
  localparam int L0_CNT_W = 13;
  localparam int L1_CNT_W = 11;

  localparam logic [2:0] CSEL_L0 = 3'b001;
  localparam logic [2:0] CSEL_L1 = 3'b011;

  localparam int ERR_CSEL    = 0;
  localparam int ERR_L1_ADDR = 1;
  localparam int ERR_STATE   = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [IMG_AW-1:0] row,
                                                 input logic [IMG_AW-1:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/conv_host_mem_if.sv
// Host/engine-facing signal bundle; master is the conv engine plus host loader, slave is the memory block.
interface conv_host_mem_if;
  import conv_pkg::*;

  logic                ld_en;
  logic [ADDR_W-1:0]   ld_addr;
  logic [DATA_W-1:0]   ld_data;
  logic                start;
  logic                busy;
  logic [ADDR_W-1:0]   iaddr;
  logic [DATA_W-1:0]   idata;
  logic                cwr;
  logic                crd;
  logic [ADDR_W-1:0]   caddr_wr;
  logic [ADDR_W-1:0]   caddr_rd;
  logic [DATA_W-1:0]   cdata_wr;
  logic [2:0]          csel;
  logic [DATA_W-1:0]   cdata_rd;
  logic                ready;
  logic                done;
  logic [2:0]          err;
  logic [L0_CNT_W-1:0] l0_cnt;
  logic [L1_CNT_W-1:0] l1_cnt;
  logic                dbg_l1;
  logic [ADDR_W-1:0]   dbg_addr;
  logic [DATA_W-1:0]   dbg_data;

  modport master (
    output ld_en, ld_addr, ld_data, start, busy, iaddr,
           cwr, crd, caddr_wr, caddr_rd, cdata_wr, csel, dbg_l1, dbg_addr,
    input  idata, cdata_rd, ready, done, err, l0_cnt, l1_cnt, dbg_data
  );

  modport slave (
    input  ld_en, ld_addr, ld_data, start, busy, iaddr,
           cwr, crd, caddr_wr, caddr_rd, cdata_wr, csel, dbg_l1, dbg_addr,
    output idata, cdata_rd, ready, done, err, l0_cnt, l1_cnt, dbg_data
  );
endinterface

// File: rtl/conv_host_mem_sram.sv
// Register-array memory: one synchronous write port, two asynchronous read ports.
// Reads see the pre-edge contents, so a same-cycle read of a written address returns old data.
module conv_sram #(
  parameter  int DEPTH = 4096,
  parameter  int WIDTH = 20,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr_a,
  output logic [WIDTH-1:0] o_rdata_a,
  input  logic [AW-1:0]    i_raddr_b,
  output logic [WIDTH-1:0] o_rdata_b
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];
endmodule

// File: rtl/conv_host_mem.sv
// Image, L0 and L1 storage for the CONV engine with run-control FSM, write counters and sticky error flags.
// Memory arrays are never reset; only control state, counters and flags are.
module conv_host_mem
  import conv_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  conv_host_mem_if.slave bus
);
  state_t              r_state;
  logic                r_ready;
  logic                r_done;
  logic [2:0]          r_err;
  logic [L0_CNT_W-1:0] r_l0_cnt;
  logic [L1_CNT_W-1:0] r_l1_cnt;

  logic w_host_side, w_run, w_start_ok;
  logic w_sel_l0, w_sel_l1, w_l1_addr_ok;
  logic w_img_we, w_l0_we, w_l1_we;
  logic [2:0] w_err_set;
  logic [DATA_W-1:0] w_l0_rd, w_l1_rd, w_l0_dbg, w_l1_dbg, w_img_rd_b;

  assign w_host_side  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_run        = (r_state == S_RUN);
  assign w_start_ok   = w_host_side && bus.start;
  assign w_sel_l0     = (bus.csel == CSEL_L0);
  assign w_sel_l1     = (bus.csel == CSEL_L1);
  assign w_l1_addr_ok = (bus.caddr_wr[ADDR_W-1:L1_AW] == '0);

  assign w_img_we = w_host_side && bus.ld_en;
  assign w_l0_we  = w_run && bus.cwr && w_sel_l0;
  assign w_l1_we  = w_run && bus.cwr && w_sel_l1 && w_l1_addr_ok;

  always_comb begin
    w_err_set              = '0;
    w_err_set[ERR_CSEL]    = bus.cwr && !w_sel_l0 && !w_sel_l1;
    w_err_set[ERR_L1_ADDR] = bus.cwr && w_sel_l1 && !w_l1_addr_ok;
    w_err_set[ERR_STATE]   = (bus.cwr || bus.crd) && !w_run;
  end

  // ready/done are registered alongside the state so they change on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (bus.start) begin
          r_state <= S_READY;
          r_ready <= 1'b1;
          r_done  <= 1'b0;
        end
        S_READY: if (bus.busy) begin
          r_state <= S_RUN;
          r_ready <= 1'b0;
        end
        S_RUN: if (!bus.busy) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // An accepted start wipes the previous run's statistics before anything new accrues.
  always_ff @(posedge clk) begin
    if (reset || w_start_ok) begin
      r_err    <= '0;
      r_l0_cnt <= '0;
      r_l1_cnt <= '0;
    end else begin
      r_err <= r_err | w_err_set;
      if (w_l0_we && (r_l0_cnt != '1)) r_l0_cnt <= r_l0_cnt + 1'b1;
      if (w_l1_we && (r_l1_cnt != '1)) r_l1_cnt <= r_l1_cnt + 1'b1;
    end
  end

  conv_sram #(.DEPTH(IMG_W * IMG_W), .WIDTH(DATA_W)) u_img (
    .clk       (clk),
    .i_we      (w_img_we),
    .i_waddr   (bus.ld_addr),
    .i_wdata   (bus.ld_data),
    .i_raddr_a (bus.iaddr),
    .o_rdata_a (bus.idata),
    .i_raddr_b (bus.ld_addr),
    .o_rdata_b (w_img_rd_b)
  );

  conv_sram #(.DEPTH(L0_DEPTH), .WIDTH(DATA_W)) u_l0 (
    .clk       (clk),
    .i_we      (w_l0_we),
    .i_waddr   (bus.caddr_wr),
    .i_wdata   (bus.cdata_wr),
    .i_raddr_a (bus.caddr_rd),
    .o_rdata_a (w_l0_rd),
    .i_raddr_b (bus.dbg_addr),
    .o_rdata_b (w_l0_dbg)
  );

  conv_sram #(.DEPTH(L1_DEPTH), .WIDTH(DATA_W)) u_l1 (
    .clk       (clk),
    .i_we      (w_l1_we),
    .i_waddr   (bus.caddr_wr[L1_AW-1:0]),
    .i_wdata   (bus.cdata_wr),
    .i_raddr_a (bus.caddr_rd[L1_AW-1:0]),
    .o_rdata_a (w_l1_rd),
    .i_raddr_b (bus.dbg_addr[L1_AW-1:0]),
    .o_rdata_b (w_l1_dbg)
  );

  always_comb begin
    bus.cdata_rd = '0;
    if (bus.crd && w_sel_l0)      bus.cdata_rd = w_l0_rd;
    else if (bus.crd && w_sel_l1) bus.cdata_rd = w_l1_rd;
  end

  assign bus.dbg_data = bus.dbg_l1 ? w_l1_dbg : w_l0_dbg;
  assign bus.ready    = r_ready;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.l0_cnt   = r_l0_cnt;
  assign bus.l1_cnt   = r_l1_cnt;
endmodule

// File: tb/tb_conv_host_mem.sv
// Scoreboard-driven bench for conv_host_mem: reference arrays hold expected memory contents.
module tb_conv_host_mem;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  conv_host_mem_if bus ();

  conv_host_mem u_dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [19:0] img_m [4096];
  logic [19:0] l0_m  [4096];
  logic [19:0] l1_m  [1024];
  logic [19:0] sb_q  [$];
  logic [19:0] exp20;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ld_en = 0; bus.ld_addr = 0; bus.ld_data = 0; bus.start = 0; bus.busy = 0;
    bus.iaddr = 0; bus.cwr = 0; bus.crd = 0; bus.caddr_wr = 0; bus.caddr_rd = 0;
    bus.cdata_wr = 0; bus.csel = 0; bus.dbg_l1 = 0; bus.dbg_addr = 0;
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick(); reset = 0;
    n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.err !== 3'b000) begin n_err++; $display("FAIL reset_err: got %b want 000", bus.err); end
    n_cmp++; if (bus.l0_cnt !== 13'd0 || bus.l1_cnt !== 11'd0) begin
      n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.l0_cnt, bus.l1_cnt); end
  endtask

  task automatic test_preload_start();
    logic [11:0] addrs [3];
    logic [19:0] dats  [3];
    addrs[0] = 12'h041; dats[0] = 20'h00100;
    addrs[1] = 12'h000; dats[1] = 20'hFEDCB;
    addrs[2] = 12'hFFF; dats[2] = 20'h3C3C3;
    for (int i = 0; i < 3; i++) begin
      bus.ld_en = 1; bus.ld_addr = addrs[i]; bus.ld_data = dats[i];
      img_m[addrs[i]] = dats[i];
      tick();
    end
    // load and start in the same cycle: both take effect
    bus.ld_addr = 12'h7FF; bus.ld_data = 20'h0ABCD; bus.start = 1;
    img_m[12'h7FF] = 20'h0ABCD;
    tick();
    bus.ld_en = 0; bus.start = 0;
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL start_ready: got %b want 1", bus.ready); end
    for (int i = 0; i < 4; i++) begin
      logic [11:0] a;
      a = (i == 3) ? 12'h7FF : addrs[i];
      sb_q.push_back(img_m[a]); bus.iaddr = a; #1;
      exp20 = sb_q.pop_front();
      n_cmp++; if (bus.idata !== exp20) begin n_err++; $display("FAIL idata[%h]: got %h want %h", a, bus.idata, exp20); end
    end
    bus.busy = 1;
    tick();
    n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL busy_ready: got %b want 0", bus.ready); end
    // image writes are ignored while the engine owns the memory
    bus.ld_en = 1; bus.ld_addr = 12'h041; bus.ld_data = 20'hFFFFF;
    tick();
    bus.ld_en = 0;
    sb_q.push_back(img_m[12'h041]); bus.iaddr = 12'h041; #1;
    exp20 = sb_q.pop_front();
    n_cmp++; if (bus.idata !== exp20) begin n_err++; $display("FAIL run_ld_ignored: got %h want %h", bus.idata, exp20); end
  endtask

  task automatic test_l0_write();
    bus.cwr = 1; bus.csel = CSEL_L0; bus.caddr_wr = 12'h005; bus.cdata_wr = 20'h12345;
    l0_m[12'h005] = 20'h12345;
    tick();
    bus.cwr = 0;
    sb_q.push_back(l0_m[12'h005]); bus.dbg_l1 = 0; bus.dbg_addr = 12'h005; #1;
    exp20 = sb_q.pop_front();
    n_cmp++; if (bus.dbg_data !== exp20) begin n_err++; $display("FAIL l0_dbg: got %h want %h", bus.dbg_data, exp20); end
    sb_q.push_back(l0_m[12'h005]); bus.crd = 1; bus.caddr_rd = 12'h005; #1;
    exp20 = sb_q.pop_front();
    n_cmp++; if (bus.cdata_rd !== exp20) begin n_err++; $display("FAIL l0_crd: got %h want %h", bus.cdata_rd, exp20); end
    bus.crd = 0; #1;
    n_cmp++; if (bus.cdata_rd !== 20'h0) begin n_err++; $display("FAIL crd_off: got %h want 0", bus.cdata_rd); end
    n_cmp++; if (bus.l0_cnt !== 13'd1) begin n_err++; $display("FAIL l0_cnt1: got %0d want 1", bus.l0_cnt); end
  endtask

  task automatic test_rdw();
    bus.cwr = 1; bus.csel = CSEL_L1; bus.caddr_wr = 12'h3FF; bus.cdata_wr = 20'h0;
    l1_m[10'h3FF] = 20'h0;
    tick();
    bus.crd = 1; bus.caddr_rd = 12'h3FF; bus.cdata_wr = 20'hABCDE;
    sb_q.push_back(l1_m[10'h3FF]); #1;
    exp20 = sb_q.pop_front();
    n_cmp++; if (bus.cdata_rd !== exp20) begin n_err++; $display("FAIL rdw_old: got %h want %h", bus.cdata_rd, exp20); end
    l1_m[10'h3FF] = 20'hABCDE;
    tick();
    bus.cwr = 0;
    sb_q.push_back(l1_m[10'h3FF]); #1;
    exp20 = sb_q.pop_front();
    n_cmp++; if (bus.cdata_rd !== exp20) begin n_err++; $display("FAIL rdw_new: got %h want %h", bus.cdata_rd, exp20); end
    bus.crd = 0;
    n_cmp++; if (bus.l1_cnt !== 11'd2) begin n_err++; $display("FAIL l1_cnt2: got %0d want 2", bus.l1_cnt); end
  endtask

  task automatic test_errors();
    bus.cwr = 1; bus.csel = 3'b010; bus.caddr_wr = 12'h005; bus.cdata_wr = 20'h55555;
    tick();
    bus.csel = CSEL_L1; bus.caddr_wr = 12'h400; bus.cdata_wr = 20'h77777;
    tick();
    bus.cwr = 0;
    n_cmp++; if (bus.err !== 3'b011) begin n_err++; $display("FAIL err_011: got %b want 011", bus.err); end
    n_cmp++; if (bus.l1_cnt !== 11'd2 || bus.l0_cnt !== 13'd1) begin
      n_err++; $display("FAIL err_cnt: got %0d/%0d want 1/2", bus.l0_cnt, bus.l1_cnt); end
    sb_q.push_back(l0_m[12'h005]); bus.dbg_l1 = 0; bus.dbg_addr = 12'h005; #1;
    exp20 = sb_q.pop_front();
    n_cmp++; if (bus.dbg_data !== exp20) begin n_err++; $display("FAIL err_drop_l0: got %h want %h", bus.dbg_data, exp20); end
    bus.busy = 0;
    tick();
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL done1: got %b want 1", bus.done); end
    bus.cwr = 1; bus.csel = CSEL_L0; bus.caddr_wr = 12'h006; bus.cdata_wr = 20'h0F0F0;
    tick();
    bus.cwr = 0;
    n_cmp++; if (bus.err !== 3'b111 || bus.l0_cnt !== 13'd1) begin
      n_err++; $display("FAIL err_state: got err %b cnt %0d want 111/1", bus.err, bus.l0_cnt); end
  endtask

  task automatic test_full_run();
    bus.start = 1; tick(); bus.start = 0;
    n_cmp++; if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.err !== 3'b000 || bus.l0_cnt !== 13'd0) begin
      n_err++; $display("FAIL restart: got rdy %b done %b err %b cnt %0d want 1/0/000/0",
                        bus.ready, bus.done, bus.err, bus.l0_cnt); end
    bus.busy = 1; tick();
    bus.cwr = 1; bus.csel = CSEL_L0;
    for (int i = 0; i < 4096; i++) begin
      bus.caddr_wr = 12'(i); bus.cdata_wr = 20'(i * 13 + 1); l0_m[i] = 20'(i * 13 + 1);
      tick();
    end
    bus.csel = CSEL_L1;
    for (int i = 0; i < 1024; i++) begin
      bus.caddr_wr = 12'(i); bus.cdata_wr = 20'(i ^ 20'h5A5A5); l1_m[i] = 20'(i ^ 20'h5A5A5);
      tick();
    end
    bus.cwr = 0; bus.busy = 0;
    tick();
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL full_done: got %b want 1", bus.done); end
    n_cmp++; if (bus.l0_cnt !== 13'd4096 || bus.l1_cnt !== 11'd1024) begin
      n_err++; $display("FAIL full_cnt: got %0d/%0d want 4096/1024", bus.l0_cnt, bus.l1_cnt); end
    n_cmp++; if (bus.err !== 3'b000) begin n_err++; $display("FAIL full_err: got %b want 000", bus.err); end
    for (int k = 0; k < 6; k++) begin
      logic [11:0] a;
      a = 12'((k * 1237) % 4096);
      bus.dbg_l1 = k[0]; bus.dbg_addr = k[0] ? {2'b00, a[9:0]} : a;
      sb_q.push_back(k[0] ? l1_m[a[9:0]] : l0_m[a]); #1;
      exp20 = sb_q.pop_front();
      n_cmp++; if (bus.dbg_data !== exp20) begin
        n_err++; $display("FAIL full_dbg[%0d] L%0d %h: got %h want %h", k, k[0], bus.dbg_addr, bus.dbg_data, exp20); end
    end
  endtask

  task automatic test_saturate();
    bus.start = 1; tick(); bus.start = 0;
    bus.busy = 1; tick();
    bus.cwr = 1; bus.csel = CSEL_L0;
    for (int i = 0; i < 8200; i++) begin
      bus.caddr_wr = 12'(i); bus.cdata_wr = 20'(i * 7); l0_m[i % 4096] = 20'(i * 7);
      tick();
    end
    bus.csel = CSEL_L1;
    for (int i = 0; i < 2100; i++) begin
      bus.caddr_wr = 12'(i % 1024); bus.cdata_wr = 20'(i * 3); l1_m[i % 1024] = 20'(i * 3);
      tick();
    end
    bus.cwr = 0; bus.busy = 0;
    tick();
    n_cmp++; if (bus.l0_cnt !== 13'h1FFF) begin n_err++; $display("FAIL sat_l0: got %0d want 8191", bus.l0_cnt); end
    n_cmp++; if (bus.l1_cnt !== 11'h7FF) begin n_err++; $display("FAIL sat_l1: got %0d want 2047", bus.l1_cnt); end
  endtask

  task automatic test_reset_midrun();
    bus.start = 1; tick(); bus.start = 0;
    bus.busy = 1; tick();
    bus.cwr = 1; bus.csel = CSEL_L0;
    for (int i = 0; i < 3; i++) begin
      bus.caddr_wr = 12'(16 + i); bus.cdata_wr = 20'hC0DE0 + 20'(i); l0_m[16 + i] = 20'hC0DE0 + 20'(i);
      tick();
    end
    bus.cwr = 0;
    n_cmp++; if (bus.l0_cnt !== 13'd3) begin n_err++; $display("FAIL mid_cnt: got %0d want 3", bus.l0_cnt); end
    reset = 1; tick(); reset = 0; bus.busy = 0;
    n_cmp++; if (bus.ready !== 1'b0 || bus.done !== 1'b0 || bus.err !== 3'b000 ||
                 bus.l0_cnt !== 13'd0 || bus.l1_cnt !== 11'd0) begin
      n_err++; $display("FAIL mid_reset: got rdy %b done %b err %b cnt %0d/%0d want 0/0/000/0/0",
                        bus.ready, bus.done, bus.err, bus.l0_cnt, bus.l1_cnt); end
    sb_q.push_back(img_m[12'h041]); bus.iaddr = 12'h041; #1;
    exp20 = sb_q.pop_front();
    n_cmp++; if (bus.idata !== exp20) begin n_err++; $display("FAIL mid_img: got %h want %h", bus.idata, exp20); end
    sb_q.push_back(l0_m[17]); bus.dbg_l1 = 0; bus.dbg_addr = 12'd17; #1;
    exp20 = sb_q.pop_front();
    n_cmp++; if (bus.dbg_data !== exp20) begin n_err++; $display("FAIL mid_l0: got %h want %h", bus.dbg_data, exp20); end
    bus.start = 1; tick(); bus.start = 0;
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL rerun_ready: got %b want 1", bus.ready); end
    bus.busy = 1; tick(); bus.busy = 0; tick();
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL rerun_done: got %b want 1", bus.done); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_preload_start();
    test_l0_write();
    test_rdw();
    test_errors();
    test_full_run();
    test_saturate();
    test_reset_midrun();
    if (sb_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_leftover: got %0d want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/conv_host_mem.md
CONV_HOST_MEM -- requirements
Module: conv_host_mem

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ld_en  in  1  image preload write strobe.
REQ-004 ld_addr  in  12  image preload address, {row,col}.
REQ-005 ld_data  in  20  image preload pixel, Q4.16.
REQ-006 start  in  1  one-cycle request to launch a CONV run.
REQ-007 busy  in  1  engine busy, from conv.
REQ-008 iaddr  in  12  image read address, from conv.
REQ-009 idata  out  20  image pixel at iaddr.
REQ-010 cwr, crd  in  1 each  layer-memory write and read enables.
REQ-011 caddr_wr, caddr_rd  in  12 each  layer-memory write and read addresses.
REQ-012 cdata_wr  in  20  layer-memory write data.
REQ-013 csel  in  3  memory select: 3'b001 selects L0 (4096x20), 3'b011 selects L1 (1024x20).
REQ-014 cdata_rd  out  20  layer-memory read data.
REQ-015 ready  out  1  image-ready handshake to conv.
REQ-016 done  out  1  run complete, level.
REQ-017 err  out  3  sticky protocol-error flags.
REQ-018 l0_cnt / l1_cnt  out  13 / 11  committed write counts for L0 / L1.
REQ-019 dbg_l1, dbg_addr  in  1, 12  backdoor select (0 = L0, 1 = L1) and address; dbg_data  out  20  backdoor read.

Function
REQ-020 The FSM SHALL have states S_IDLE, S_READY, S_RUN and S_DONE.
REQ-021 Transitions SHALL be: S_IDLE/S_DONE→S_READY on start; S_READY→S_RUN when busy=1; S_RUN→S_DONE when busy=0.
REQ-022 ready SHALL be a registered output, 1 exactly while in S_READY; it drops the cycle after busy=1 is sampled.
REQ-023 done SHALL be 1 while in S_DONE.
REQ-024 ld_en SHALL write image[ld_addr]=ld_data only in S_IDLE/S_DONE; in other states it is ignored.
REQ-025 When ld_en and start occur in the same cycle, the load SHALL commit and the start SHALL be taken.
REQ-026 start SHALL be ignored outside S_IDLE/S_DONE; an accepted start clears l0_cnt, l1_cnt and err.
REQ-027 idata SHALL be the combinational read image[iaddr], valid in all states.
REQ-028 When cwr=1 in S_RUN with csel=001, the block SHALL write L0[caddr_wr]=cdata_wr at the edge and increment l0_cnt.
REQ-029 When cwr=1 in S_RUN with csel=011 and caddr_wr[11:10]=0, it SHALL write L1[caddr_wr[9:0]]=cdata_wr and increment l1_cnt.
REQ-030 cdata_rd SHALL be combinational: L0[caddr_rd] if crd=1 and csel=001, L1[caddr_rd[9:0]] if crd=1 and csel=011, otherwise 0.
REQ-031 On a same-cycle read and write to the same address, cdata_rd SHALL return the old data, with the new data visible the next cycle.
REQ-032 err[0] SHALL set on cwr=1 with csel not in {001,011}; the write is dropped.
REQ-033 err[1] SHALL set on an L1 write with caddr_wr[11:10]≠0; the write is dropped.
REQ-034 err[2] SHALL set on cwr or crd outside S_RUN; writes are dropped.
REQ-035 l0_cnt and l1_cnt SHALL saturate at all-ones; err bits SHALL stay set until reset or an accepted start.
REQ-036 dbg_data SHALL be the combinational read of L0[dbg_addr] or L1[dbg_addr[9:0]], usable in any state.

Reset
REQ-037 On reset the block SHALL enter S_IDLE with ready=0, done=0, err=0, l0_cnt=0 and l1_cnt=0.
REQ-038 Reset SHALL NOT clear the memory arrays.
REQ-039 Reset mid-run SHALL abort to S_IDLE; the next start re-runs with the existing image.

Structure
REQ-040 Package conv_pkg SHALL hold the CSEL_L0=3'b001 and CSEL_L1=3'b011 constants, IMG_W=64, the state enum and the err bit indices.
REQ-041 Sub-module conv_sram (parameterised depth/width, one synchronous write port, two asynchronous read ports) SHALL be instantiated for image, L0 and L1.

Verification
REQ-042 Preload image[12'h041]=20'h00100, then start → ready=1 the next cycle; busy=1 → ready=0 one cycle later, state S_RUN.
REQ-043 In S_RUN, cwr=1, csel=001, caddr_wr=12'h005, cdata_wr=20'h12345 → dbg_l1=0, dbg_addr=12'h005 reads 20'h12345 and l0_cnt=1.
REQ-044 Same cycle: cwr=1 and crd=1, csel=011, address 12'h3FF, new data 20'hABCDE, old data 0 → cdata_rd=0 that cycle and 20'hABCDE the next.
REQ-045 cwr=1 with csel=3'b010, then an L1 write to caddr_wr=12'h400 → err=3'b011, both writes dropped, l1_cnt unchanged.
REQ-046 A full conv run (4096 L0 writes, 1024 L1 writes), then busy falls → done=1, l0_cnt=4096, l1_cnt=1024, err=0.
REQ-047 Reset asserted during S_RUN → S_IDLE, all outputs at reset values, image contents intact on a following idata read.
